// File: rtl/io_synchroniser_bank.sv
// Multi-channel input conditioner: per-channel metastability synchroniser,
// stability filter and registered rise/fall edge detection.
module io_synchroniser_bank #(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      STAGES        = 2,
  parameter int unsigned      FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  // FILTER_CYCLES of 0 and 1 both collapse to a single-cycle qualification.
  localparam int unsigned   NEFF     = (FILTER_CYCLES < 1) ? 1 : FILTER_CYCLES;
  localparam int unsigned   CW       = $clog2(NEFF + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NEFF - 1);

  if (STAGES < 2) begin : g_bad_stages
    $error("io_synchroniser_bank: STAGES must be at least 2");
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("io_synchroniser_bank: WIDTH must be in 1..32");
  end

  (* async_reg = "true" *) logic [STAGES-1:0] chain [WIDTH];
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] update;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        chain[i] <= {STAGES{RESET_VALUE[i]}};
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        chain[i] <= {chain[i][STAGES-2:0], data_in[i]};
      end
    end
  end

  always_comb begin
    sync_out = '0;
    update   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sync_out[i] = chain[i][STAGES-1];
      update[i]   = (chain[i][STAGES-1] != data_out[i]) && (cnt[i] == CNT_LAST);
    end
    rise_nxt = update & sync_out;
    fall_nxt = update & ~sync_out;
  end

  // Counter clears on any match, so a short excursion never accumulates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= RESET_VALUE;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync_out[i] == data_out[i]) begin
          cnt[i] <= '0;
        end else if (update[i]) begin
          data_out[i] <= sync_out[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      rise    <= rise_nxt;
      fall    <= fall_nxt;
      changed <= |(rise_nxt | fall_nxt);
    end
  end

endmodule

// File: tb/tb_io_synchroniser_bank.sv
// Bench for io_synchroniser_bank: four parameterisations share one stimulus,
// checked by directed sequences, a vector table and a window-based model.
module tb_io_synchroniser_bank;

  localparam int ND = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic [7:0] o_dout [ND];
  logic [7:0] o_rise [ND];
  logic [7:0] o_fall [ND];
  logic       o_chg  [ND];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  io_synchroniser_bank #(.WIDTH(8), .STAGES(2), .FILTER_CYCLES(4), .RESET_VALUE(8'hA5)) u_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_out(o_dout[0]),
    .rise(o_rise[0]), .fall(o_fall[0]), .changed(o_chg[0]));
  io_synchroniser_bank #(.WIDTH(8), .STAGES(2), .FILTER_CYCLES(4), .RESET_VALUE(8'h00)) u_b (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_out(o_dout[1]),
    .rise(o_rise[1]), .fall(o_fall[1]), .changed(o_chg[1]));
  io_synchroniser_bank #(.WIDTH(8), .STAGES(3), .FILTER_CYCLES(0), .RESET_VALUE(8'h00)) u_c (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_out(o_dout[2]),
    .rise(o_rise[2]), .fall(o_fall[2]), .changed(o_chg[2]));
  io_synchroniser_bank #(.WIDTH(8), .STAGES(3), .FILTER_CYCLES(1), .RESET_VALUE(8'h00)) u_d (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_out(o_dout[3]),
    .rise(o_rise[3]), .fall(o_fall[3]), .changed(o_chg[3]));

  function automatic int stg(input int d);
    return (d < 2) ? 2 : 3;
  endfunction

  function automatic int nfc(input int d);
    return (d < 2) ? 4 : 1;
  endfunction

  function automatic logic [7:0] rv(input int d);
    return (d == 0) ? 8'hA5 : 8'h00;
  endfunction

  // Reference: h[d][k] is the input sampled k+1 edges ago. A bit flips when
  // every synchronised sample in the last max(N,1) edges disagrees with it.
  logic [7:0] h      [ND][8];
  logic [7:0] m_dout [ND];
  logic [7:0] m_rise [ND];
  logic [7:0] m_fall [ND];
  logic       m_chg  [ND];

  function automatic logic [7:0] win_mask(input int d);
    logic [7:0] m;
    m = 8'hFF;
    for (int j = 0; j < nfc(d); j++) m &= h[d][stg(d) + j - 1] ^ m_dout[d];
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < ND; d++) begin
        for (int k = 0; k < 8; k++) h[d][k] <= rv(d);
        m_dout[d] <= rv(d);
        m_rise[d] <= 8'h00;
        m_fall[d] <= 8'h00;
        m_chg[d]  <= 1'b0;
      end
    end else begin
      for (int d = 0; d < ND; d++) begin
        for (int k = 7; k > 0; k--) h[d][k] <= h[d][k-1];
        h[d][0]   <= data_in;
        m_dout[d] <= m_dout[d] ^ win_mask(d);
        m_rise[d] <= win_mask(d) & ~m_dout[d];
        m_fall[d] <= win_mask(d) & m_dout[d];
        m_chg[d]  <= |win_mask(d);
      end
    end
  end

  task automatic ck(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < ND; d++) begin
        ck($sformatf("model_dout[%0d]", d), {24'h0, o_dout[d]}, {24'h0, m_dout[d]});
        ck($sformatf("model_rise[%0d]", d), {24'h0, o_rise[d]}, {24'h0, m_rise[d]});
        ck($sformatf("model_fall[%0d]", d), {24'h0, o_fall[d]}, {24'h0, m_fall[d]});
        ck($sformatf("model_chg[%0d]", d), {31'h0, o_chg[d]}, {31'h0, m_chg[d]});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] din;
    int         cyc;
    logic [7:0] dout;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       chg;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [7];
    int   pulses;
    logic flag;
    logic nv;

    tbl[0] = '{din: 8'h00, cyc: 10, dout: 8'h00, rise: 8'h00, fall: 8'h00, chg: 1'b0};
    tbl[1] = '{din: 8'h3C, cyc: 5,  dout: 8'h00, rise: 8'h00, fall: 8'h00, chg: 1'b0};
    tbl[2] = '{din: 8'h3C, cyc: 1,  dout: 8'h3C, rise: 8'h3C, fall: 8'h00, chg: 1'b1};
    tbl[3] = '{din: 8'h3C, cyc: 1,  dout: 8'h3C, rise: 8'h00, fall: 8'h00, chg: 1'b0};
    tbl[4] = '{din: 8'h0F, cyc: 5,  dout: 8'h3C, rise: 8'h00, fall: 8'h00, chg: 1'b0};
    tbl[5] = '{din: 8'h0F, cyc: 1,  dout: 8'h0F, rise: 8'h03, fall: 8'h30, chg: 1'b1};
    tbl[6] = '{din: 8'h0F, cyc: 1,  dout: 8'h0F, rise: 8'h00, fall: 8'h00, chg: 1'b0};

    // Reset defaults with inputs driven opposite to RESET_VALUE
    rst_n   = 1'b0;
    data_in = 8'hFF;
    tick(4);
    chk_en = 1'b1;
    ck("rst_dout_a", {24'h0, o_dout[0]}, 32'hA5);
    ck("rst_rise_a", {24'h0, o_rise[0]}, 32'h0);
    ck("rst_fall_a", {24'h0, o_fall[0]}, 32'h0);
    ck("rst_chg_a",  {31'h0, o_chg[0]},  32'h0);
    ck("rst_dout_b", {24'h0, o_dout[1]}, 32'h0);

    rst_n   = 1'b1;
    data_in = 8'hA5;
    pulses  = 0;
    repeat (50) begin
      tick(1);
      if ((o_rise[0] | o_fall[0]) != 8'h00 || o_chg[0]) pulses++;
    end
    ck("idle_pulses_a", pulses, 0);
    data_in = 8'h00;
    tick(20);

    // Latency: STAGES+N = 6 edges
    data_in = 8'h01;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      ck($sformatf("lat_hold_%0d", i), {31'h0, o_dout[1][0]}, 32'h0);
    end
    tick(1);
    ck("lat_dout", {31'h0, o_dout[1][0]}, 32'h1);
    ck("lat_rise", {24'h0, o_rise[1]}, 32'h01);
    ck("lat_chg",  {31'h0, o_chg[1]},  32'h1);
    tick(1);
    ck("lat_rise_end", {24'h0, o_rise[1]}, 32'h0);
    data_in = 8'h00;
    tick(20);

    // Glitch: 3-cycle pulse rejected, 4-cycle pulse accepted
    data_in = 8'h08;
    tick(3);
    data_in = 8'h00;
    flag = 1'b0;
    repeat (12) begin
      tick(1);
      flag |= o_dout[1][3] | o_rise[1][3] | o_fall[1][3];
    end
    ck("glitch_short", {31'h0, flag}, 32'h0);
    data_in = 8'h08;
    tick(4);
    data_in = 8'h00;
    tick(2);
    ck("glitch_rise", {24'h0, o_rise[1]}, 32'h08);
    ck("glitch_dout_hi", {24'h0, o_dout[1]}, 32'h08);
    tick(4);
    ck("glitch_fall", {24'h0, o_fall[1]}, 32'h08);
    ck("glitch_dout_lo", {24'h0, o_dout[1]}, 32'h00);
    tick(10);

    // Multi-channel vector table on the STAGES=2, N=4 instance
    for (int r = 0; r < 7; r++) begin
      data_in = tbl[r].din;
      tick(tbl[r].cyc);
      ck($sformatf("tbl%0d_dout", r), {24'h0, o_dout[1]}, {24'h0, tbl[r].dout});
      ck($sformatf("tbl%0d_rise", r), {24'h0, o_rise[1]}, {24'h0, tbl[r].rise});
      ck($sformatf("tbl%0d_fall", r), {24'h0, o_fall[1]}, {24'h0, tbl[r].fall});
      ck($sformatf("tbl%0d_chg", r),  {31'h0, o_chg[1]},  {31'h0, tbl[r].chg});
    end
    data_in = 8'h00;
    tick(20);

    // Unfiltered, STAGES=3: latency 4 for both N=0 and N=1
    for (int t = 0; t < 4; t++) begin
      nv = ~data_in[1];
      data_in[1] = nv;
      tick(3);
      for (int d = 2; d < 4; d++)
        ck($sformatf("unf_old_%0d_%0d", d, t), {31'h0, o_dout[d][1]}, {31'h0, ~nv});
      tick(1);
      for (int d = 2; d < 4; d++) begin
        ck($sformatf("unf_new_%0d_%0d", d, t), {31'h0, o_dout[d][1]}, {31'h0, nv});
        ck($sformatf("unf_rise_%0d_%0d", d, t), {24'h0, o_rise[d]}, nv ? 32'h02 : 32'h00);
        ck($sformatf("unf_fall_%0d_%0d", d, t), {24'h0, o_fall[d]}, nv ? 32'h00 : 32'h02);
      end
      tick(1);
    end
    data_in = 8'h00;
    tick(20);

    // Reset mid-filter, asserted between edges
    data_in = 8'h04;
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    ck("mid_rst_async_a", {24'h0, o_dout[0]}, 32'hA5);
    ck("mid_rst_dout_b",  {24'h0, o_dout[1]}, 32'h00);
    ck("mid_rst_rise_b",  {24'h0, o_rise[1]}, 32'h00);
    tick(2);
    ck("mid_rst_hold_b",  {31'h0, o_chg[1]}, 32'h0);
    rst_n = 1'b1;
    tick(5);
    ck("mid_rel_hold", {31'h0, o_dout[1][2]}, 32'h0);
    tick(1);
    ck("mid_rel_rise", {24'h0, o_rise[1]}, 32'h04);
    ck("mid_rel_dout", {24'h0, o_dout[1]}, 32'h04);

    // Randomised toggling with occasional asynchronous resets
    repeat (3000) begin
      tick(1);
      for (int b = 0; b < 8; b++)
        if ($urandom_range(5) == 0) data_in[b] = ~data_in[b];
      if ($urandom_range(499) == 0) begin
        #3 rst_n = 1'b0;
        tick(1 + $urandom_range(2));
        rst_n = 1'b1;
      end
    end

    tick(2);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
